// File: rtl/frame_timing_gen.sv
// frame_timing_gen -- video master timebase for the MC6847X display path.
// Free-running pixel/line counters drive sync, blank/border/viewport
// classification, per-line byte fetch strobes and the character-ROM row
// counter. Every output is registered from the counter state of the previous
// clock, so all outputs share one clock of latency.
//
// Ports:
//   clk, reset_n      pixel clock, asynchronous active-low reset
//   format            0=NTSC, 1=PAL; taken only on the last clock of a frame
//   width             bytes fetched per viewport line (8, 16, else 32)
//   char_rows         rows per character cell minus one
//   hsn, fsn          horizontal / vertical sync, active low
//   active            00=blank, 10=border, 11=viewport
//   fetch_stb         one pulse per byte to fetch, fetch_idx = byte index
//   preload           coincides with the fetch_idx=0 strobe
//   alpha_row         character-ROM row, rowclear pulses when it wraps
//   view_row          viewport line index, 0 outside the viewport
//   line_start        pulse at h_count=0, frame_start at h=0,v=0
//   blink             only with FRAME_TIMING_BLINK_EN: bit 4 of a frame counter
module frame_timing_gen #(
  parameter int H_TOTAL      = 458,
  parameter int H_SYNC       = 28,
  parameter int H_BLANK      = 38,
  parameter int PORT_X       = 129,
  parameter int PORT_W       = 256,
  parameter int V_TOTAL_NTSC = 262,
  parameter int V_TOTAL_PAL  = 312,
  parameter int V_SYNC       = 8,
  parameter int PORT_Y_NTSC  = 63,
  parameter int PORT_Y_PAL   = 88,
  parameter int PORT_H       = 192,
  parameter int PRELOAD_LEAD = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       format,
  input  logic [5:0] width,
  input  logic [3:0] char_rows,
  output logic       hsn,
  output logic       fsn,
  output logic [1:0] active,
  output logic       fetch_stb,
  output logic [4:0] fetch_idx,
  output logic       preload,
  output logic [3:0] alpha_row,
  output logic       rowclear,
  output logic [7:0] view_row,
  output logic       line_start,
  output logic       frame_start
`ifdef FRAME_TIMING_BLINK_EN
  ,
  output logic       blink
`endif
);

  localparam int VMAX    = (V_TOTAL_PAL > V_TOTAL_NTSC) ? V_TOTAL_PAL : V_TOTAL_NTSC;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(VMAX);
  localparam int FETCH_X = PORT_X - PRELOAD_LEAD;

  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic          fmt_q;
  logic [5:0]    width_q;
  logic [HW:0]   next_x;   // column of the next fetch strobe on this line
  logic [5:0]    fetch_k;  // strobes issued so far on this line

  logic [VW-1:0] v_last_val, port_y;
  logic [VW:0]   port_end;
  logic [HW:0]   step;
  logic          h_last, v_last, vp_line, in_cols, fetch_hit;
  logic [1:0]    act_next;

  always_comb begin
    v_last_val = fmt_q ? VW'(V_TOTAL_PAL - 1) : VW'(V_TOTAL_NTSC - 1);
    port_y     = fmt_q ? VW'(PORT_Y_PAL) : VW'(PORT_Y_NTSC);
    port_end   = {1'b0, port_y} + (VW+1)'(PORT_H);
    h_last     = (h_count == HW'(H_TOTAL - 1));
    v_last     = (v_count == v_last_val);
    vp_line    = (v_count >= port_y) && ({1'b0, v_count} < port_end);
    in_cols    = (h_count >= HW'(PORT_X)) && ({1'b0, h_count} < (HW+1)'(PORT_X + PORT_W));
    case (width_q)
      6'd8:    step = (HW+1)'(PORT_W / 8);
      6'd16:   step = (HW+1)'(PORT_W / 16);
      default: step = (HW+1)'(PORT_W / 32);
    endcase
    // fetch_k caps the count, so next_x running past the line end is harmless
    fetch_hit  = vp_line && (fetch_k < width_q) && ({1'b0, h_count} == next_x);
    act_next   = 2'b10;
    if (v_count < VW'(V_SYNC) || h_count < HW'(H_BLANK)) act_next = 2'b00;
    else if (vp_line && in_cols)                         act_next = 2'b11;
  end

`ifdef FRAME_TIMING_BLINK_EN
  logic [4:0] frame_cnt;
  assign blink = frame_cnt[4];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_count     <= '0;
      v_count     <= '0;
      fmt_q       <= 1'b0;
      width_q     <= 6'd8;
      next_x      <= (HW+1)'(FETCH_X);
      fetch_k     <= '0;
      hsn         <= 1'b0;
      fsn         <= 1'b0;
      active      <= 2'b00;
      fetch_stb   <= 1'b0;
      fetch_idx   <= '0;
      preload     <= 1'b0;
      alpha_row   <= '0;
      rowclear    <= 1'b0;
      view_row    <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
`ifdef FRAME_TIMING_BLINK_EN
      frame_cnt   <= '0;
`endif
    end else begin
      // counters
      if (h_last) begin
        h_count <= '0;
        v_count <= v_last ? '0 : v_count + 1'b1;
        // format only switches between frames, so a frame never mixes geometries
        if (v_last) fmt_q <= format;
        width_q <= (width == 6'd8 || width == 6'd16) ? width : 6'd32;
        next_x  <= (HW+1)'(FETCH_X);
        fetch_k <= '0;
      end else begin
        h_count <= h_count + 1'b1;
        if (fetch_hit) begin
          next_x  <= next_x + step;
          fetch_k <= fetch_k + 1'b1;
        end
      end

      // registered decode of the pre-edge counter state
      hsn         <= (h_count >= HW'(H_SYNC));
      fsn         <= (v_count >= VW'(V_SYNC));
      active      <= act_next;
      fetch_stb   <= fetch_hit;
      preload     <= fetch_hit && (fetch_k == 6'd0);
      if (h_last)         fetch_idx <= '0;
      else if (fetch_hit) fetch_idx <= fetch_k[4:0];
      // >= rather than == so a char_rows cut below the current row still wraps
      rowclear    <= vp_line && h_last && (alpha_row >= char_rows);
      if (!vp_line)    alpha_row <= '0;
      else if (h_last) alpha_row <= (alpha_row >= char_rows) ? 4'd0 : alpha_row + 4'd1;
      view_row    <= vp_line ? 8'(v_count - port_y) : 8'd0;
      line_start  <= (h_count == '0);
      frame_start <= (h_count == '0) && (v_count == '0);
`ifdef FRAME_TIMING_BLINK_EN
      if (h_count == '0 && v_count == '0) frame_cnt <= frame_cnt + 5'd1;
`endif
    end
  end

endmodule
